// File: rtl/spi_pkg.sv
// Shared constants, state encoding and frame packing for the SPI register-write link.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Peripheral register file map on the far end of the link
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_e;

    // Frame word layout: R/W bit, 7-bit address, 8-bit data, sent MSB first
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that times one SPI phase of CLK_DIV clk cycles.
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    output logic phase_first,
    output logic phase_end
);

    localparam int            CW     = 8;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Reload on phase entry, otherwise count down and park at zero
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = RELOAD;
        end else if (count_reg != '0) begin
            count_next = count_reg - 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // First cycle of a phase is the one right after a reload; with CLK_DIV=1 it is also the last
    assign phase_first = (count_reg == RELOAD);
    assign phase_end   = (count_reg == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit {rw, addr, data} frame per request and
// captures the last 8 CIPO bits of the frame as read-back data.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    input  logic       cipo
);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must lie in 1..255");
        end
    endgenerate

    spi_state_e            state_reg;
    spi_state_e            state_next;
    logic [FRAME_BITS-1:0] tx_shift_reg;
    logic [FRAME_BITS-1:0] tx_shift_next;
    logic [7:0]            rx_shift_reg;
    logic [7:0]            rx_shift_next;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic                  ncs_reg;
    logic                  ncs_next;
    logic                  sclk_reg;
    logic                  sclk_next;
    logic                  copi_reg;
    logic                  copi_next;
    logic                  done_reg;
    logic                  done_next;
    logic [7:0]            rdata_reg;
    logic [7:0]            rdata_next;

    logic phase_load;
    logic phase_first;
    logic phase_end;

    // Every state change starts a fresh CLK_DIV-long phase
    assign phase_load = (state_next != state_reg);

    spi_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .clk        (clk),
        .srst       (rst),
        .load       (phase_load),
        .phase_first(phase_first),
        .phase_end  (phase_end)
    );

    // State, shift registers and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            ncs_reg      <= 1'b1;
            sclk_reg     <= 1'b0;
            copi_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            ncs_reg      <= ncs_next;
            sclk_reg     <= sclk_next;
            copi_reg     <= copi_next;
            done_reg     <= done_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Next-state and shift datapath: bits advance only at the end of a HIGH phase
    always_comb begin
        state_next    = state_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    tx_shift_next = pack_frame(rw, addr, wdata);
                    rx_shift_next = '0;
                    bit_cnt_next  = CNT_W'(FRAME_BITS - 1);
                    state_next    = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_first) begin
                    rx_shift_next = {rx_shift_reg[6:0], cipo};
                end
                if (phase_end) begin
                    if (bit_cnt_reg == '0) begin
                        state_next = HOLD;
                    end else begin
                        bit_cnt_next  = bit_cnt_reg - 1'b1;
                        tx_shift_next = {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                        state_next    = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin values for the upcoming state; copi only moves while sclk is low
    always_comb begin
        ncs_next   = 1'b1;
        sclk_next  = 1'b0;
        copi_next  = 1'b0;
        done_next  = 1'b0;
        rdata_next = rdata_reg;
        case (state_next)
            SETUP, LOW: begin
                ncs_next  = 1'b0;
                copi_next = tx_shift_next[FRAME_BITS-1];
            end
            HIGH: begin
                ncs_next  = 1'b0;
                sclk_next = 1'b1;
                copi_next = copi_reg;
            end
            HOLD: begin
                ncs_next = 1'b0;
            end
            default: begin
                ncs_next = 1'b1;
            end
        endcase
        if (state_reg == GAP && state_next == IDLE) begin
            done_next  = 1'b1;
            rdata_next = rx_shift_reg;
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign rdata = rdata_reg;
    assign ncs   = ncs_reg;
    assign sclk  = sclk_reg;
    assign copi  = copi_reg;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: table-driven frames on a CLK_DIV=4 instance, abort and
// ignored-start sequences, randomized back-to-back frames on a CLK_DIV=1 instance,
// and a protocol monitor acting as the SPI target on both instances.
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       rw    [2];
    logic [6:0] addr  [2];
    logic [7:0] wdata [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] rdata [2];
    logic       ncs   [2];
    logic       sclk  [2];
    logic       copi  [2];
    logic       cipo  [2];

    int cdiv [2] = '{DIV0, DIV1};

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(DIV0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .rw(rw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
        .ncs(ncs[0]), .sclk(sclk[0]), .copi(copi[0]), .cipo(cipo[0])
    );

    spi_controller #(.CLK_DIV(DIV1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .rw(rw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
        .ncs(ncs[1]), .sclk(sclk[1]), .copi(copi[1]), .cipo(cipo[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int min);
        total++;
        if (act < min) begin
            bad++;
            $display("FAIL %s: got=%0d want>=%0d", nm, act, min);
        end
    endtask

    // ---------------- target model / protocol monitor ----------------
    int          edge_no = 0;
    logic        prev_ncs   [2] = '{1'b1, 1'b1};
    logic        prev_sclk  [2] = '{1'b0, 1'b0};
    logic        prev_copi  [2] = '{1'b0, 1'b0};
    int          ncs_fall_cyc [2];
    int          ncs_rise_cyc [2];
    int          last_fall    [2];
    int          last_rise    [2];
    int          rise_cnt     [2] = '{0, 0};
    int          drv_idx      [2] = '{-1, -1};
    int          done_cnt     [2] = '{0, 0};
    int          last_rises   [2] = '{0, 0};
    bit          have_rise    [2] = '{1'b0, 1'b0};
    logic [15:0] copi_word  [2];
    logic [15:0] last_word  [2];
    logic [15:0] drive_word [2];
    bit          abort_window = 1'b0;

    initial begin
        cipo[0] = 1'b0;
        cipo[1] = 1'b0;
    end

    always @(posedge clk) edge_no <= edge_no + 1;

    // Sample pins just after each edge; drive cipo like a mode-0 target (changes on sclk fall)
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] === 1'b1) begin
                check($sformatf("copi_stable[%0d]", i), 32'(copi[i]), 32'(prev_copi[i]));
            end
            if (prev_ncs[i] === 1'b1 && ncs[i] === 1'b0) begin
                if (have_rise[i]) begin
                    check_ge($sformatf("ncs_high_gap[%0d]", i), edge_no - ncs_rise_cyc[i], cdiv[i] + 1);
                end
                ncs_fall_cyc[i] = edge_no;
                rise_cnt[i]     = 0;
                copi_word[i]    = '0;
                cipo[i]         = drive_word[i][15];
                drv_idx[i]      = 14;
            end
            if (prev_sclk[i] === 1'b0 && sclk[i] === 1'b1) begin
                if (rise_cnt[i] == 0) begin
                    check_ge($sformatf("ncs_lead[%0d]", i), edge_no - ncs_fall_cyc[i], cdiv[i]);
                end else begin
                    check($sformatf("sclk_period[%0d]", i), 32'(edge_no - last_rise[i]), 32'(2 * cdiv[i]));
                end
                check($sformatf("ncs_low_at_rise[%0d]", i), 32'(ncs[i]), 32'd0);
                copi_word[i] = {copi_word[i][14:0], copi[i]};
                rise_cnt[i]++;
                last_rise[i] = edge_no;
            end
            if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b0) begin
                last_fall[i] = edge_no;
                if (drv_idx[i] >= 0) begin
                    cipo[i] = drive_word[i][drv_idx[i]];
                    drv_idx[i]--;
                end
            end
            if (prev_ncs[i] === 1'b0 && ncs[i] === 1'b1) begin
                if (!abort_window) begin
                    check_ge($sformatf("ncs_trail[%0d]", i), edge_no - last_fall[i], cdiv[i]);
                end
                ncs_rise_cyc[i] = edge_no;
                have_rise[i]    = 1'b1;
                last_word[i]    = copi_word[i];
                last_rises[i]   = rise_cnt[i];
            end
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
            end
            prev_ncs[i]  = ncs[i];
            prev_sclk[i] = sclk[i];
            prev_copi[i] = copi[i];
        end
    end

    // ---------------- single frame on one instance ----------------
    task automatic run_frame(input int d, input logic r, input logic [6:0] a, input logic [7:0] w,
                             input logic [15:0] cw, input int poke_at,
                             input logic [15:0] exp_word, input logic [7:0] exp_rdata, input string tag);
        int n;
        int busy_n;
        bit got;
        n      = 1;
        busy_n = 0;
        got    = 1'b0;
        drive_word[d] = cw;
        @(negedge clk);
        start[d] = 1'b1;
        rw[d]    = r;
        addr[d]  = a;
        wdata[d] = w;
        @(posedge clk);
        #2;
        start[d] = 1'b0;
        rw[d]    = ~r;
        addr[d]  = ~a;
        wdata[d] = ~w;
        while (n <= 40 * cdiv[d] + 10) begin
            if (done[d] === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy[d] === 1'b1) busy_n++;
            if (n == poke_at) begin
                start[d] = 1'b1;
                rw[d]    = ~r;
                addr[d]  = a ^ 7'h2A;
                wdata[d] = w ^ 8'hFF;
            end
            if (n == poke_at + 1) start[d] = 1'b0;
            @(posedge clk);
            #2;
            n++;
        end
        start[d] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s/timeout: got=no done want=done within %0d cycles", tag, 40 * cdiv[d] + 10);
            return;
        end
        $display("frame %s: word=0x%04h rdata=0x%02h latency=%0d", tag, last_word[d], rdata[d], n);
        check({tag, "/latency"},  32'(n), 32'(34 * cdiv[d] + 1));
        check({tag, "/busy_len"}, 32'(busy_n), 32'(34 * cdiv[d]));
        check({tag, "/busy_at_done"}, 32'(busy[d]), 32'd0);
        check({tag, "/word"},  32'(last_word[d]), 32'(exp_word));
        check({tag, "/rises"}, 32'(last_rises[d]), 32'd16);
        check({tag, "/rdata"}, 32'(rdata[d]), 32'(exp_rdata));
        @(posedge clk);
        #2;
        check({tag, "/done_pulse"}, 32'(done[d]), 32'd0);
        check({tag, "/no_requeue"}, 32'(busy[d]), 32'd0);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] cw;
        int          poke;
        logic [15:0] exp_word;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [4];

    localparam int NB2B = 6;
    logic        b_rw [NB2B];
    logic [6:0]  b_ad [NB2B];
    logic [7:0]  b_wd [NB2B];
    logic [15:0] b_cw [NB2B];

    initial begin
        #500000;
        $display("FAIL watchdog: got=time limit want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn0;
        int n;
        int f;
        int prev_done_edge;
        bit got;
        logic        r;
        logic [6:0]  a;
        logic [7:0]  w;
        logic [15:0] cw;
        int          pk;

        vecs[0] = '{RW_WRITE, ADDR_PWM_DUTY,    8'h80, 16'h1234, 0,  16'h8480, 8'h34};
        vecs[1] = '{RW_READ,  ADDR_EN_OUT_7_0,  8'h00, 16'h3CA5, 0,  16'h0000, 8'hA5};
        vecs[2] = '{RW_WRITE, ADDR_EN_PWM_15_8, 8'hC3, 16'h0F5A, 20, 16'h83C3, 8'h5A};
        vecs[3] = '{RW_READ,  ADDR_EN_PWM_7_0,  8'h7E, 16'h9966, 0,  16'h027E, 8'h66};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            rw[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            drive_word[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset/ncs[%0d]", i),   32'(ncs[i]),   32'd1);
            check($sformatf("reset/sclk[%0d]", i),  32'(sclk[i]),  32'd0);
            check($sformatf("reset/copi[%0d]", i),  32'(copi[i]),  32'd0);
            check($sformatf("reset/busy[%0d]", i),  32'(busy[i]),  32'd0);
            check($sformatf("reset/done[%0d]", i),  32'(done[i]),  32'd0);
            check($sformatf("reset/rdata[%0d]", i), 32'(rdata[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        for (int v = 0; v < 4; v++) begin
            run_frame(0, vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].cw, vecs[v].poke,
                      vecs[v].exp_word, vecs[v].exp_rdata, $sformatf("vec%0d", v));
            repeat (3) @(posedge clk);
            #2;
        end

        // Abort after the 8th sclk rise
        drive_word[0] = 16'hFFFF;
        dn0 = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        rw[0]    = RW_WRITE;
        addr[0]  = 7'h12;
        wdata[0] = 8'h34;
        @(posedge clk);
        #2;
        start[0] = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 400) begin
            if (rise_cnt[0] == 8 && sclk[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
            n++;
        end
        check("abort/reached_rise8", 32'(got), 32'd1);
        abort_window = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        $display("abort: ncs=%0b sclk=%0b busy=%0b rdata=0x%02h", ncs[0], sclk[0], busy[0], rdata[0]);
        check("abort/ncs",   32'(ncs[0]),   32'd1);
        check("abort/sclk",  32'(sclk[0]),  32'd0);
        check("abort/busy",  32'(busy[0]),  32'd0);
        check("abort/rdata", 32'(rdata[0]), 32'd0);
        check("abort/done",  32'(done[0]),  32'd0);
        repeat (40 * DIV0) @(posedge clk);
        #2;
        abort_window = 1'b0;
        check("abort/no_done", 32'(done_cnt[0] - dn0), 32'd0);
        check("abort/idle_ncs", 32'(ncs[0]), 32'd1);

        run_frame(0, RW_WRITE, ADDR_EN_OUT_15_8, 8'h55, 16'hC3E1, 0, 16'h8155, 8'hE1, "after_abort");
        repeat (3) @(posedge clk);
        #2;

        // Randomized single frames with an optional ignored start mid-frame
        for (int k = 0; k < 3; k++) begin
            r  = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            w  = 8'($urandom_range(0, 255));
            cw = 16'($urandom_range(0, 65535));
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 120)) : 0;
            run_frame(0, r, a, w, cw, pk, {r, a, w}, cw[7:0], $sformatf("rnd%0d", k));
            repeat (2) @(posedge clk);
            #2;
        end

        // Back-to-back frames on the CLK_DIV=1 instance with start held high
        for (int k = 0; k < NB2B; k++) begin
            b_rw[k] = 1'($urandom_range(0, 1));
            b_ad[k] = 7'($urandom_range(0, 127));
            b_wd[k] = 8'($urandom_range(0, 255));
            b_cw[k] = 16'($urandom_range(0, 65535));
        end
        drive_word[1] = b_cw[0];
        @(negedge clk);
        start[1] = 1'b1;
        rw[1]    = b_rw[0];
        addr[1]  = b_ad[0];
        wdata[1] = b_wd[0];
        f = 0;
        n = 0;
        prev_done_edge = 0;
        while (f < NB2B && n < NB2B * 40) begin
            @(posedge clk);
            #2;
            n++;
            if (done[1] === 1'b1) begin
                $display("b2b frame %0d: word=0x%04h rdata=0x%02h", f, last_word[1], rdata[1]);
                check($sformatf("b2b%0d/word", f),  32'(last_word[1]), 32'({b_rw[f], b_ad[f], b_wd[f]}));
                check($sformatf("b2b%0d/rdata", f), 32'(rdata[1]), 32'(b_cw[f][7:0]));
                check($sformatf("b2b%0d/rises", f), 32'(last_rises[1]), 32'd16);
                if (f > 0) begin
                    check($sformatf("b2b%0d/done_period", f), 32'(edge_no - prev_done_edge), 32'd35);
                end
                prev_done_edge = edge_no;
                f++;
                if (f < NB2B) begin
                    rw[1]    = b_rw[f];
                    addr[1]  = b_ad[f];
                    wdata[1] = b_wd[f];
                    drive_word[1] = b_cw[f];
                end else begin
                    start[1] = 1'b0;
                end
            end
        end
        start[1] = 1'b0;
        check("b2b/frames_done", 32'(f), 32'(NB2B));
        repeat (5) @(posedge clk);
        #2;
        check("b2b/idle", 32'(busy[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
